cr_sa_counter_bank: RTL and testbench

Parametrised bank of statistics/activity counters for the CCEIP debug and performance path. Each of `NUM_CNT` counters independently selects one bit from a 2-D event bus via a registered mux. Each counter supports enable, per-counter clear, and a wrap or saturate mode with sticky overflow. A global snapshot captures all counters coherently in one cycle.

---
 rtl/cr_sa_counter_bank_if.sv | 42 ++++
 rtl/cr_sa_counter_bank.sv | 105 ++++++++++
 tb/tb_cr_sa_counter_bank.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_sa_counter_bank_if.sv
// Bus bundle for cr_sa_counter_bank: event inputs, per-counter controls and count outputs.
// Threshold signals exist only when CR_SA_CNT_THRESH_EN is defined.
interface cr_sa_counter_bank_if #(
    parameter int NUM_CNT = 4,
    parameter int NUM_GRP = 16,
    parameter int EVT_W   = 64,
    parameter int CNT_W   = 50,
    parameter int SEL_W   = $clog2(NUM_GRP) + $clog2(EVT_W)
);
    logic [NUM_GRP-1:0][EVT_W-1:0] sa_events;
    logic [NUM_CNT-1:0][SEL_W-1:0] sa_event_sel;
    logic [NUM_CNT-1:0]            sa_enable;
    logic [NUM_CNT-1:0]            sa_sat_mode;
    logic [NUM_CNT-1:0]            sa_clear;
    logic                          sa_snap;
    logic [NUM_CNT-1:0][CNT_W-1:0] sa_count;
    logic [NUM_CNT-1:0][CNT_W-1:0] sa_snapshot;
    logic [NUM_CNT-1:0]            sa_ovf;

`ifdef CR_SA_CNT_THRESH_EN
    logic [NUM_CNT-1:0][CNT_W-1:0] sa_thresh;
    logic [NUM_CNT-1:0]            sa_thresh_hit;

    modport master (
        output sa_events, sa_event_sel, sa_enable, sa_sat_mode, sa_clear, sa_snap, sa_thresh,
        input  sa_count, sa_snapshot, sa_ovf, sa_thresh_hit
    );
    modport slave (
        input  sa_events, sa_event_sel, sa_enable, sa_sat_mode, sa_clear, sa_snap, sa_thresh,
        output sa_count, sa_snapshot, sa_ovf, sa_thresh_hit
    );
`else
    modport master (
        output sa_events, sa_event_sel, sa_enable, sa_sat_mode, sa_clear, sa_snap,
        input  sa_count, sa_snapshot, sa_ovf
    );
    modport slave (
        input  sa_events, sa_event_sel, sa_enable, sa_sat_mode, sa_clear, sa_snap,
        output sa_count, sa_snapshot, sa_ovf
    );
`endif
endinterface

// File: rtl/cr_sa_counter_bank.sv
// Bank of NUM_CNT event counters with registered event select, wrap/saturate, sticky
// overflow and a coherent global snapshot. Define CR_SA_CNT_THRESH_EN for threshold flags.
module cr_sa_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int NUM_GRP = 16,
    parameter int EVT_W   = 64,
    parameter int CNT_W   = 50
) (
    input logic                 clk,
    input logic                 rst_n,
    cr_sa_counter_bank_if.slave bus
);
    localparam int GRP_W = $clog2(NUM_GRP);
    localparam int BIT_W = $clog2(EVT_W);
    localparam int SEL_W = GRP_W + BIT_W;
    localparam logic [GRP_W:0] GRP_LIMIT = (GRP_W+1)'(NUM_GRP);

    logic [NUM_CNT-1:0]            evt_d, evt_q;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_d, cnt_q, snap_q;
    logic [NUM_CNT-1:0]            ovf_d, ovf_q;
    logic [GRP_W-1:0]              grp;
    logic [BIT_W-1:0]              bit_idx;

    // Stage 1: pick the selected event bit; group codes past NUM_GRP read as no event.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        evt_d   = '0;
        grp     = '0;
        bit_idx = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            grp     = bus.sa_event_sel[i][SEL_W-1 -: GRP_W];
            bit_idx = bus.sa_event_sel[i][BIT_W-1:0];
            if ({1'b0, grp} < GRP_LIMIT) begin
                evt_d[i] = bus.sa_events[grp][bit_idx];
            end
        end
    end

`ifdef CR_SA_CNT_THRESH_EN
    logic [NUM_CNT-1:0] hit_d, hit_q;
`endif

    // Stage 2: clear beats increment; enable is applied here so it can kill a piped event.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
`ifdef CR_SA_CNT_THRESH_EN
        hit_d = hit_q;
`endif
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.sa_clear[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
`ifdef CR_SA_CNT_THRESH_EN
                hit_d[i] = 1'b0;
`endif
            end else if (evt_q[i] && bus.sa_enable[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = bus.sa_sat_mode[i] ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
`ifdef CR_SA_CNT_THRESH_EN
                    // Only a real increment can land on the threshold; zero never fires.
                    if ((bus.sa_thresh[i] != '0) && (cnt_d[i] == bus.sa_thresh[i])) begin
                        hit_d[i] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= '0;
            snap_q <= '0;
`ifdef CR_SA_CNT_THRESH_EN
            hit_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            evt_q <= evt_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
`ifdef CR_SA_CNT_THRESH_EN
            hit_q <= hit_d;
`endif
            // Snapshot takes the registered count, so a same-cycle clear or increment is excluded.
            if (bus.sa_snap) begin
                snap_q <= cnt_q;
            end
        end
    end

    assign bus.sa_count    = cnt_q;
    assign bus.sa_snapshot = snap_q;
    assign bus.sa_ovf      = ovf_q;
`ifdef CR_SA_CNT_THRESH_EN
    assign bus.sa_thresh_hit = hit_q;
`endif

endmodule

// File: tb/tb_cr_sa_counter_bank.sv
// Scoreboard bench for cr_sa_counter_bank: directed scenarios plus random traffic checked
// against an arithmetic reference model. Threshold checks follow CR_SA_CNT_THRESH_EN.
module tb_cr_sa_counter_bank;
    localparam int NC = 4;
    localparam int NG = 12;
    localparam int EW = 64;
    localparam int CW = 8;
    localparam int SW = $clog2(NG) + $clog2(EW);
    localparam longint unsigned MAXV = (64'd1 << CW) - 64'd1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cr_sa_counter_bank_if #(.NUM_CNT(NC), .NUM_GRP(NG), .EVT_W(EW), .CNT_W(CW)) bus ();
    cr_sa_counter_bank #(.NUM_CNT(NC), .NUM_GRP(NG), .EVT_W(EW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [NG-1:0][EW-1:0] s_events;
    logic [NC-1:0][SW-1:0] s_sel;
    logic [NC-1:0]         s_en, s_sat, s_clr;
    logic                  s_snap;
    logic [NC-1:0][CW-1:0] s_thr;

    longint unsigned m_cnt [NC];
    longint unsigned m_snap[NC];
    bit              m_ovf [NC];
    bit              m_hit [NC];
    bit              m_pipe[NC];

    typedef struct {
        logic [NC-1:0][CW-1:0] cnt;
        logic [NC-1:0][CW-1:0] snap;
        logic [NC-1:0]         ovf;
        logic [NC-1:0]         hit;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit event_of(input int i);
        int sel_v = int'(s_sel[i]);
        int g     = sel_v / EW;
        int b     = sel_v % EW;
        if (g >= NG) return 1'b0;
        return s_events[g][b];
    endfunction

    task automatic drive_bus();
        bus.sa_events    = s_events;
        bus.sa_event_sel = s_sel;
        bus.sa_enable    = s_en;
        bus.sa_sat_mode  = s_sat;
        bus.sa_clear     = s_clr;
        bus.sa_snap      = s_snap;
`ifdef CR_SA_CNT_THRESH_EN
        bus.sa_thresh    = s_thr;
`endif
    endtask

    // Drive this cycle's inputs and predict the state visible after the next rising edge.
    task automatic apply_and_model();
        exp_t e;
        bit   nxt[NC];
        drive_bus();
        for (int i = 0; i < NC; i++) nxt[i] = event_of(i);
        if (s_snap) begin
            for (int i = 0; i < NC; i++) m_snap[i] = m_cnt[i];
        end
        for (int i = 0; i < NC; i++) begin
            if (s_clr[i]) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
                m_hit[i] = 1'b0;
            end else if (m_pipe[i] && s_en[i]) begin
                if (m_cnt[i] == MAXV) begin
                    m_ovf[i] = 1'b1;
                    if (!s_sat[i]) m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (s_thr[i] != 0 && m_cnt[i] == longint'(s_thr[i])) m_hit[i] = 1'b1;
                end
            end
            m_pipe[i] = nxt[i];
        end
        for (int i = 0; i < NC; i++) begin
            e.cnt[i]  = CW'(m_cnt[i]);
            e.snap[i] = CW'(m_snap[i]);
            e.ovf[i]  = m_ovf[i];
            e.hit[i]  = m_hit[i];
        end
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        apply_and_model();
    endtask

    task automatic idle_inputs();
        s_events = '0;
        s_clr    = '0;
        s_snap   = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", 64'(bus.sa_count), 64'd0);
        check("rst_snapshot", 64'(bus.sa_snapshot), 64'd0);
        check("rst_ovf", 64'(bus.sa_ovf), 64'd0);
`ifdef CR_SA_CNT_THRESH_EN
        check("rst_thresh_hit", 64'(bus.sa_thresh_hit), 64'd0);
`endif
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 1'b0; m_hit[i] = 1'b0; m_pipe[i] = 1'b0;
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        apply_and_model();
    endtask

    task automatic random_events();
        for (int g = 0; g < NG; g++) begin
            s_events[g] = {$urandom, $urandom} & {$urandom, $urandom};
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction just after each rising edge.
    exp_t got;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("count", 64'(bus.sa_count), 64'(got.cnt));
                check("snapshot", 64'(bus.sa_snapshot), 64'(got.snap));
                check("ovf", 64'(bus.sa_ovf), 64'(got.ovf));
`ifdef CR_SA_CNT_THRESH_EN
                check("thresh_hit", 64'(bus.sa_thresh_hit), 64'(got.hit));
`endif
            end
        end
    end

    initial begin
        int tgt[NC];
        s_sel = '0;
        s_en  = '1;
        s_sat = '0;
        s_thr = '0;
        idle_inputs();
        drive_bus();
        do_reset();

        // Basic count: group 1 bit 5 pulsed for 10 cycles on counter 0.
        s_sel[0] = SW'(10'h045);
        repeat (10) begin
            s_events = '0;
            s_events[1][5] = 1'b1;
            step();
        end
        idle_inputs();
        repeat (3) step();

        // Wrap (counter 0) vs saturate (counter 1) through 257 events.
        s_sel[1] = SW'(10'h045);
        s_sat    = 4'b0010;
        s_clr    = 4'b0011;
        step();
        s_clr = '0;
        repeat (257) begin
            s_events[1][5] = 1'b1;
            step();
        end
        idle_inputs();
        repeat (2) step();

        // Clear colliding with a piped event, followed by a fresh event.
        s_events[1][5] = 1'b1;
        step();
        s_clr[0] = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();

        // Coherent snapshot at 7/3/0/100 with a concurrent increment on counter 0.
        s_sat = '0;
        for (int i = 0; i < NC; i++) s_sel[i] = SW'((2 * EW) + i);
        tgt = '{7, 3, 0, 100};
        s_clr = '1;
        step();
        s_clr = '0;
        for (int c = 0; c < 100; c++) begin
            s_events = '0;
            for (int i = 0; i < NC; i++) s_events[2][i] = (c < tgt[i]);
            step();
        end
        idle_inputs();
        repeat (2) step();
        s_events[2][0] = 1'b1;
        step();
        idle_inputs();
        s_snap = 1'b1;
        step();
        s_snap = 1'b0;
        repeat (2) step();

        // Invalid group selects while the whole bus toggles.
        s_sel[2] = SW'((13 * EW) + 3);
        s_sel[3] = SW'((15 * EW) + 63);
        s_clr    = 4'b1100;
        step();
        s_clr = '0;
        repeat (20) begin
            random_events();
            step();
        end
        idle_inputs();
        repeat (2) step();

        // Enable dropped while an event sits in the pipe.
        s_sel[0] = SW'(10'h045);
        s_events[1][5] = 1'b1;
        step();
        idle_inputs();
        s_en[0] = 1'b0;
        step();
        s_en[0] = 1'b1;
        repeat (2) step();

        // Threshold of 5 on counter 3, then 10 events and a clear.
        s_sel[3] = SW'(10'h045);
        s_thr[3] = CW'(5);
        s_clr[3] = 1'b1;
        step();
        s_clr = '0;
        repeat (10) begin
            s_events[1][5] = 1'b1;
            step();
        end
        idle_inputs();
        repeat (2) step();
        s_clr[3] = 1'b1;
        step();
        s_clr = '0;
        step();

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                random_events();
                for (int i = 0; i < NC; i++) begin
                    if ($urandom_range(7) == 0) s_sel[i] = SW'($urandom);
                    if ($urandom_range(3) == 0) s_sel[i] = SW'(EW + i);
                    s_en[i]  = ($urandom_range(7) != 0);
                    s_clr[i] = ($urandom_range(63) == 0);
                    if ($urandom_range(31) == 0) s_sat[i] = 1'($urandom);
                    if ($urandom_range(31) == 0) s_thr[i] = CW'($urandom_range(20));
                end
                s_snap = ($urandom_range(7) == 0);
                step();
            end
        end
        idle_inputs();
        step();

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
